stream_master_rate: RTL
=======================

# stream_master_rate

Output-side AXI4-Stream master for the FIR accelerator. Accepts the FIR result stream (`FIR_DATA_BUS`) and the frame-end strobe `last_in` from the input-side slave's delay pipe. Decimates by a run-time rate, buffers kept samples in a small synchronous FIFO, and presents them on an AXI4-Stream master port with TLAST on the final sample of each frame. Back-pressure from TREADY reaches the FIR datapath through `is_ready`.

## Interface
- `FIFO_DEPTH`, 16: output FIFO entries; power of two, ≥ 4.
- `AFULL_MARGIN`, 12: free entries needed for `is_ready`=1; must be ≥ FIR pipeline latency + 2.
- `M_AXIS_ACLK`  in  1  clock.
- `M_AXIS_ARESETN`  in  1  reset, asynchronous, active-low.
- `stream_in`  in  `FIR_DATA_BUS`  FIR output: `.data`, `.valid`.
- `last_in`  in  1  frame end; coincident with the frame's final `stream_in.valid`.
- `rate`  in  `FIR_DOWN_RATE`  keep 1 of every rate+1 samples; 0 = pass-through. Changed only between frames.
- `is_ready`  out  1  FIFO has ≥ AFULL_MARGIN free entries.
- `overflow`  out  1  sticky; sample written while FIFO full.
- `M_AXIS_TVALID`  out  1.
- `M_AXIS_TDATA`  out  `$bits(FIR_DATA_SAMPLE)`.
- `M_AXIS_TSTRB`  out  `$bits(FIR_DATA_SAMPLE)/8`  constant all ones.
- `M_AXIS_TLAST`  out  1.
- `M_AXIS_TREADY`  in  1.

## Operation
- Phase counter `phase` (`FIR_DOWN_RATE` width) advances only on `stream_in.valid`.
- Keep rule: keep when `phase`==0 or `last_in`==1. Discarded samples never enter the FIFO.
- Counter update on valid: `last_in`=1 → 0; else `phase`==`rate` → 0; else `phase`+1. `rate` compared at `phase` width, no overflow possible.
- FIFO word = {data, last}. Kept sample pushed with last=`last_in`.
- Push with FIFO full and no pop this cycle: sample dropped, `overflow` set until reset. Push and pop in the same cycle while full: accepted.
- `last_in` without `stream_in.valid`: ignored (protocol error; no TLAST generated).
- Output FSM:
  - EMPTY: TVALID=0. Go to VALID when FIFO non-empty.
  - VALID: TVALID=1, TDATA/TLAST from head. On TVALID&&TREADY: pop; stay if another entry exists, else EMPTY.
- TDATA/TLAST stable while TVALID=1 and TREADY=0. TVALID never drops without a handshake.
- `is_ready` = (FIFO_DEPTH − occupancy) ≥ AFULL_MARGIN, from registered occupancy.

## Timing
- Reset values: TVALID=0, TDATA=0, TLAST=0, `is_ready`=1, `overflow`=0, `phase`=0, FIFO empty.
- Sample valid at edge k: in FIFO after k; TVALID=1 in cycle k+1 if FIFO was empty. Latency 1 cycle.
- Throughput: 1 sample/cycle with TREADY held high.
- `is_ready` updates 1 cycle after the occupancy change.
- Reset mid-frame: FIFO flushed, `phase`=0. Next sample starts a new frame with no TLAST carried over.

## Configuration
- `FIR_DECIM_EN` defined: decimation logic as above.
- Not defined: `phase` logic removed, `rate` ignored, every valid sample kept. TLAST behaviour unchanged.

## Structure
- `fir_pkg` holds `FIR_DATA_SAMPLE`, `FIR_DATA_BUS`, `FIR_DOWN_RATE` (same width as `FIR_UP_RATE`).
- Sub-module `fir_sync_fifo`, parameterised by width and depth, provides:
  - push, pop;
  - full, empty;
  - occupancy count;
  - registered head outputs.
- Decimator and AXI output FSM live in the top.

## Test plan
- `rate`=0, 8 samples 1..8, `last_in` on 8, TREADY=1 → TDATA 1..8 on consecutive cycles; TLAST only with 8; first TVALID one cycle after first input.
- `rate`=2, samples 0..11, `last_in` on 11 → output 0,3,6,9,11; TLAST with 11. Next frame starts at `phase`=0.
- `rate`=3, frame of 4 with `last_in` on sample 3 → output 0,3; TLAST=1 on 3, with no duplicate emission.
- `rate`=0, TREADY=0 for 20 cycles, continuous input → `is_ready` falls when occupancy reaches 5. Stall TDATA/TLAST stable. Releasing TREADY drains in order.
- Ignore `is_ready` and push 17 samples with TREADY=0 → `overflow`=1 stays set; FIFO holds the first 16.
- Assert reset with 6 entries queued → TVALID=0 and `is_ready`=1 immediately. Post-reset frame outputs correctly. Build without `FIR_DECIM_EN`: `rate`=2 still passes all samples.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR accelerator types: sample, bus, rate and output-FIFO word.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_RATE_W = 4;

  typedef logic signed [FIR_DATA_W-1:0] FIR_DATA_SAMPLE;
  typedef logic [FIR_RATE_W-1:0]        FIR_UP_RATE;
  typedef FIR_UP_RATE                   FIR_DOWN_RATE;

  typedef struct packed {
    FIR_DATA_SAMPLE data;
    logic           valid;
  } FIR_DATA_BUS;

  typedef struct packed {
    FIR_DATA_SAMPLE data;
    logic           last;
  } fir_out_word_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with a registered head word, so the entry at the read
// pointer is always presented from a flop, including right after a pop.
module fir_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = head_q;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // NOTE: storage is deliberately left out of reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (pop_ok) begin
      if (count_q > (AW+1)'(1)) head_d = mem_q[rd_ptr_q + AW'(1)];
      else if (push_ok)         head_d = push_data_i;
    end else if (empty_o && push_ok) begin
      head_d = push_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/stream_master_rate.sv
// FIR output AXI4-Stream master: decimator, output FIFO and TVALID FSM.
// Define FIR_DECIM_EN to build the run-time decimator; otherwise every valid sample is kept.
module stream_master_rate
  import fir_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 12
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  FIR_DATA_BUS                         stream_in,
  input  logic                                last_in,
  input  FIR_DOWN_RATE                        rate,
  output logic                                is_ready,
  output logic                                overflow,
  output logic                                M_AXIS_TVALID,
  output logic [$bits(FIR_DATA_SAMPLE)-1:0]   M_AXIS_TDATA,
  output logic [$bits(FIR_DATA_SAMPLE)/8-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          keep;
  fir_out_word_t push_word, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop, more_entries;
  out_state_e    state_q;
  logic          tvalid_q, is_ready_q, overflow_q;

`ifdef FIR_DECIM_EN
  FIR_DOWN_RATE phase_q, phase_d;

  // Frame end always forces a keep and restarts the phase for the next frame.
  always_comb begin
    phase_d = phase_q;
    keep    = 1'b0;
    if (stream_in.valid) begin
      keep = (phase_q == '0) || last_in;
      if (last_in)              phase_d = '0;
      else if (phase_q == rate) phase_d = '0;
      else                      phase_d = phase_q + FIR_DOWN_RATE'(1);
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) phase_q <= '0;
    else                 phase_q <= phase_d;
  end
`else
  logic unused_rate;
  assign unused_rate = ^rate;
  assign keep        = stream_in.valid;
`endif

  assign push_word = '{data: stream_in.data, last: last_in};
  assign pop       = tvalid_q && M_AXIS_TREADY;

  fir_sync_fifo #(
    .WIDTH ($bits(fir_out_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (M_AXIS_ACLK),
    .rst_n       (M_AXIS_ARESETN),
    .push_i      (keep),
    .push_data_i (push_word),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (head)
  );

  // During a pop any concurrent push is accepted, so it also counts as a next entry.
  assign more_entries = (fifo_count > CW'(1)) || keep;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q  <= OUT_EMPTY;
      tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        OUT_EMPTY: begin
          if (!fifo_empty) begin
            state_q  <= OUT_VALID;
            tvalid_q <= 1'b1;
          end
        end
        OUT_VALID: begin
          if (M_AXIS_TREADY && !more_entries) begin
            state_q  <= OUT_EMPTY;
            tvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= OUT_EMPTY;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      is_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      is_ready_q <= (FIFO_DEPTH - int'(fifo_count)) >= AFULL_MARGIN;
      overflow_q <= overflow_q || (keep && fifo_full && !pop);
    end
  end

  assign is_ready      = is_ready_q;
  assign overflow      = overflow_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = head.data;
  assign M_AXIS_TLAST  = head.last;
  assign M_AXIS_TSTRB  = '1;

endmodule
